// File: rtl/rv32v_divide_sequencer_pkg.sv
// Shared vector-unit types used by the divide sequencer and its neighbours.
package rv32v_divide_sequencer_pkg;

    parameter int unsigned VLMAX = 16;

    typedef enum logic {
        UNSIGNED = 1'b0,
        SIGNED   = 1'b1
    } sign_type_t;

endpackage

// File: rtl/rv32v_divide_sequencer.sv
// Walks the active elements of one vector divide request, issuing each to the scalar
// divide unit and streaming its result to writeback.
module rv32v_divide_sequencer
    import rv32v_divide_sequencer_pkg::*;
#(
    parameter int unsigned VLMAX = rv32v_divide_sequencer_pkg::VLMAX,
    parameter int unsigned IDX_W = $clog2(VLMAX)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W:0]   req_vl,
    input  logic             req_div_type,
    input  logic             req_signed,
    input  logic             req_mask_en,
    input  logic [VLMAX-1:0] req_mask,
    output logic [IDX_W-1:0] rd_idx,
    input  logic [31:0]      rd_vs1,
    input  logic [31:0]      rd_vs2,
    output logic [31:0]      vs1_data,
    output logic [31:0]      vs2_data,
    output logic             start_div,
    output logic             div_type,
    output logic             is_signed_div,
    output sign_type_t       is_signed,
    input  logic             busy_du,
    input  logic             done_du,
    input  logic             exception_du,
    input  logic [31:0]      wdata_du,
    output logic             wb_valid,
    output logic [IDX_W-1:0] wb_idx,
    output logic [31:0]      wb_data,
    output logic             cmpl_valid,
    output logic             cmpl_exception,
    output logic [IDX_W-1:0] cmpl_exc_idx
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W:0]   vl_q;
    logic             type_q;
    logic             sign_q;
    logic [VLMAX-1:0] mask_q;
    logic             is_last;

    assign is_last       = ({1'b0, idx_q} + (IDX_W + 1)'(1)) == vl_q;
    assign req_ready     = (state_q == StIdle);
    assign rd_idx        = idx_q;
    assign div_type      = type_q;
    assign is_signed_div = sign_q;
    assign is_signed     = sign_q ? SIGNED : UNSIGNED;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            vl_q           <= '0;
            type_q         <= 1'b0;
            sign_q         <= 1'b0;
            mask_q         <= '0;
            vs1_data       <= '0;
            vs2_data       <= '0;
            start_div      <= 1'b0;
            wb_valid       <= 1'b0;
            wb_idx         <= '0;
            wb_data        <= '0;
            cmpl_valid     <= 1'b0;
            cmpl_exception <= 1'b0;
            cmpl_exc_idx   <= '0;
        end else begin
            start_div  <= 1'b0;
            wb_valid   <= 1'b0;
            cmpl_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        vl_q           <= req_vl;
                        type_q         <= req_div_type;
                        sign_q         <= req_signed;
                        mask_q         <= req_mask_en ? req_mask : '1;
                        idx_q          <= '0;
                        cmpl_exception <= 1'b0;
                        cmpl_exc_idx   <= '0;
                        if (req_vl == '0) begin
                            cmpl_valid <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (!mask_q[idx_q]) begin
                        if (is_last) begin
                            cmpl_valid <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else if (!busy_du) begin
                        vs1_data  <= rd_vs1;
                        vs2_data  <= rd_vs2;
                        start_div <= 1'b1;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    // A done_du coincident with our own start pulse belongs to an older operation
                    if (done_du && !start_div) begin
                        if (exception_du) begin
                            cmpl_exception <= 1'b1;
                            cmpl_exc_idx   <= idx_q;
                            cmpl_valid     <= 1'b1;
                            state_q        <= StDone;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_idx   <= idx_q;
                            wb_data  <= wdata_du;
                            if (is_last) begin
                                state_q <= StDone;
                            end else begin
                                idx_q   <= idx_q + IDX_W'(1);
                                state_q <= StIssue;
                            end
                        end
                    end
                end
                StDone: begin
                    // Entered after a final writeback without cmpl_valid: raise it one cycle
                    // later so it never overlaps wb_valid
                    cmpl_valid <= !cmpl_valid;
                    if (cmpl_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/rv32v_divide_sequencer.md
# rv32v_divide_sequencer

Element sequencer on the requester side of the vector divide unit. Accepts one vector divide/remainder request and reads each element's operands from the vector register file read port. It issues one 32-bit element at a time to the divide unit, using the start/busy/done/exception handshake, and streams results to the writeback port. It sits in the vector execute stage between issue logic and the divide unit.

## Interface
Parameters:
- VLMAX, 16, maximum elements per request
- IDX_W, $clog2(VLMAX), element index width

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, accepts request
- req_vl  in  IDX_W+1  element count, 0..VLMAX
- req_div_type  in  1  0 = quotient, 1 = remainder
- req_signed  in  1  signed operation
- req_mask_en  in  1  apply req_mask
- req_mask  in  VLMAX  per-element enable
- rd_idx  out  IDX_W  element index for operand read
- rd_vs1  in  32  vs1[rd_idx], combinational read, same cycle
- rd_vs2  in  32  vs2[rd_idx], combinational read, same cycle
- vs1_data, vs2_data  out  32 each  divisor and dividend to the divide unit (result = vs2/vs1)
- start_div  out  1  one-cycle start pulse
- div_type, is_signed_div  out  1 each  copies of latched req_div_type and req_signed
- is_signed  out  sign_type_t  SIGNED if req_signed, else UNSIGNED
- busy_du, done_du, exception_du  in  1 each  divide unit status; done_du is a one-cycle pulse
- wdata_du  in  32  divide result, valid with done_du
- wb_valid  out  1  one-cycle writeback strobe
- wb_idx  out  IDX_W  element index
- wb_data  out  32  result
- cmpl_valid  out  1  one-cycle completion pulse
- cmpl_exception  out  1  request aborted on exception
- cmpl_exc_idx  out  IDX_W  faulting element index

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch vl, type, sign and mask. Mask is all-ones if !req_mask_en.
  - Clear idx and the exception record.
  - Go to DONE if vl==0, else go to ISSUE.
- ISSUE (rd_idx=idx):
  - Element inactive: no issue. If idx==vl-1, go to DONE; else idx++ and stay in ISSUE (one cycle per skipped element).
  - Element active and busy_du=1: hold state.
  - Element active and busy_du=0: register rd_vs1/rd_vs2 into vs1_data/vs2_data, set start_div, go to WAIT.
- WAIT:
  - start_div is high for the first WAIT cycle only. Operands stay stable until done_du.
  - done_du is ignored while start_div=1.
  - On done_du with exception_du=1: record cmpl_exc_idx=idx, set the exception flag, go to DONE. No writeback.
  - On done_du with exception_du=0: register wb_valid/wb_idx/wb_data from wdata_du. If idx==vl-1, go to DONE; else idx++ and go to ISSUE.
- DONE:
  - cmpl_valid=1 for one cycle, with cmpl_exception and cmpl_exc_idx.
  - Go to IDLE.
- RST mid-operation: on the next edge, FSM goes to IDLE and all registered outputs are cleared. A done_du that arrives after reset produces no writeback.

## Timing
- Reset values: start_div, wb_valid, wb_idx, wb_data, vs1_data, vs2_data, cmpl_valid, cmpl_exception, cmpl_exc_idx are all 0. req_ready=1 from the first cycle after RST deasserts.
- Accept at edge t. The first ISSUE cycle is t+1. start_div is high in cycle t+2.
- Writeback: wb_valid is high in the cycle after done_du. The next ISSUE is in that same cycle.
- Per-element cost: divider latency + 2 cycles.
- cmpl_valid is high one cycle after the last writeback-producing edge. For vl==0, cmpl_valid is high at t+1.
- wb_valid and cmpl_valid are never high in the same cycle.

## Structure
- sign_type_t and VLMAX come from the shared vector types package. The state enum stays local.
- Single module, no sub-modules. Counter, FSM and output registers are all in this block.

## Test plan
The bench uses a divide-unit model with fixed 4-cycle latency.
- **Signed quotient:** vl=3, signed, quotient, vs2={100,-7,9}, vs1={7,2,3} -> wb (0,14), (1,-3), (2,3); cmpl_exception=0.
- **Masked unsigned remainder:** vl=4, unsigned remainder, mask_en=1, mask=4'b0101, vs2={10,11,12,13}, vs1={3,3,5,5} -> wb only (0,1) and (2,2); exactly 2 start_div pulses.
- **Exception abort:** vl=4, model raises exception_du on element 1 -> one wb (idx 0), cmpl_exception=1, cmpl_exc_idx=1, no start_div for idx 2 or 3.
- **Empty request:** vl=0 -> cmpl_valid one cycle after accept; no start_div and no wb_valid; req_ready=1 the following cycle.
- **Busy stall:** busy_du held high for 5 cycles while in ISSUE -> start_div stays low until the cycle after busy_du falls; results are still correct.
- **Reset mid-operation:** RST pulsed in WAIT before done_du -> all outputs 0 the next cycle; a later done_du produces no wb_valid; req_ready=1 after RST deasserts.
